// File: rtl/vga_text_renderer_if.sv
// Bundle for the renderer: screen-memory and bitmap-memory lookups plus the VGA pin outputs.
// The renderer takes the master modport.
interface vga_text_renderer_if;
  logic [10:0] vga_addr;
  logic [7:0]  vga_code;
  logic [15:0] bmp_addr;
  logic [11:0] bmp_color;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output vga_addr,
    input  vga_code,
    output bmp_addr,
    input  bmp_color,
    output red,
    output green,
    output blue,
    output hsync,
    output vsync,
    output frame_start
  );

  modport slave (
    input  vga_addr,
    output vga_code,
    input  bmp_addr,
    output bmp_color,
    input  red,
    input  green,
    input  blue,
    input  hsync,
    input  vsync,
    input  frame_start
  );
endinterface

// File: rtl/vga_text_renderer.sv
// 40x30 tile text renderer on a 640x480@60 raster: tile lookup, bitmap lookup, then registered
// RGB and active-low syncs, two pixel ticks behind the raster counters.
module vga_text_renderer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input logic                 clk,
  input logic                 reset,
  vga_text_renderer_if.master bus
);

  localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic [9:0]      hcount_q, hcount_d;
  logic [9:0]      vcount_q, vcount_d;
  logic            h_last, v_last;
  logic            visible, hs_raw, vs_raw;
  logic [10:0]     tile_row, tile_col, tile_addr;

  logic [7:0]  code_q;
  logic [3:0]  py_q, px_q;
  logic        vis1_q, hs1_q, vs1_q;
  logic [11:0] rgb_q;
  logic        hsync_q, vsync_q;
  logic        frame_start_q;

  assign tick   = (cnt_q == CntW'(CLK_DIV - 1));
  assign h_last = (hcount_q == 10'(HTotal - 1));
  assign v_last = (vcount_q == 10'(VTotal - 1));

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CntW'(1);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  always_comb begin
    visible = (hcount_q < 10'(H_VIS)) && (vcount_q < 10'(V_VIS));
    hs_raw  = !((hcount_q >= 10'(H_VIS + H_FP)) && (hcount_q < 10'(H_VIS + H_FP + H_SYNC)));
    vs_raw  = !((vcount_q >= 10'(V_VIS + V_FP)) && (vcount_q < 10'(V_VIS + V_FP + V_SYNC)));
    // row*40 as (row<<5)+(row<<3); row<=29 and col<=39 while visible keeps this <=1199.
    tile_row  = {5'b0, vcount_q[9:4]};
    tile_col  = {5'b0, hcount_q[9:4]};
    tile_addr = (tile_row << 5) + (tile_row << 3) + tile_col;
    bus.vga_addr = visible ? tile_addr : 11'd0;
  end

  // Stage 1: tile code and in-tile offset
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= '0;
      py_q   <= '0;
      px_q   <= '0;
      vis1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else if (tick) begin
      code_q <= bus.vga_code;
      py_q   <= vcount_q[3:0];
      px_q   <= hcount_q[3:0];
      vis1_q <= visible;
      hs1_q  <= hs_raw;
      vs1_q  <= vs_raw;
    end
  end

  assign bus.bmp_addr = {code_q, py_q, px_q};

  // Stage 2: blanked pixel colour and syncs, kept aligned with each other
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (tick) begin
      rgb_q   <= vis1_q ? bus.bmp_color : 12'h000;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick && h_last && v_last;
    end
  end

  assign bus.red         = rgb_q[11:8];
  assign bus.green       = rgb_q[7:4];
  assign bus.blue        = rgb_q[3:0];
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench: a full-size renderer for reset/hsync/address timing, and a scaled-down renderer whose
// every tick is checked against a queue of expected pipeline outputs over whole frames.
module tb_vga_text_renderer;

  localparam int S_DIV = 2;
  localparam int S_HV = 64, S_HFP = 8, S_HS = 12, S_HBP = 12;
  localparam int S_VV = 48, S_VFP = 3, S_VS = 2, S_VBP = 3;
  localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;   // 96
  localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;   // 56
  localparam int S_FT = S_HT * S_VT;                   // 5376 ticks per frame
  localparam int T_RST = S_FT + 20 * S_HT + 30;        // second frame, (h,v)=(30,20)

  typedef struct {
    int          h;
    int          v;
    logic [15:0] bmp;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_full = 1'b1;
  logic rst_small = 1'b1;
  logic [7:0] scr [0:2047];
  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_text_renderer_if f_if ();
  vga_text_renderer_if s_if ();

  vga_text_renderer dut_full (
    .clk   (clk),
    .reset (rst_full),
    .bus   (f_if)
  );

  vga_text_renderer #(
    .CLK_DIV (S_DIV),
    .H_VIS   (S_HV),
    .H_FP    (S_HFP),
    .H_SYNC  (S_HS),
    .H_BP    (S_HBP),
    .V_VIS   (S_VV),
    .V_FP    (S_VFP),
    .V_SYNC  (S_VS),
    .V_BP    (S_VBP)
  ) dut_small (
    .clk   (clk),
    .reset (rst_small),
    .bus   (s_if)
  );

  function automatic logic [11:0] color_fn(input logic [15:0] a);
    return {a[15:8] ^ a[7:0], a[3:0]} | 12'h100;
  endfunction

  assign f_if.vga_code  = scr[f_if.vga_addr];
  assign f_if.bmp_color = 12'hFFF;
  assign s_if.vga_code  = scr[s_if.vga_addr];
  assign s_if.bmp_color = color_fn(s_if.bmp_addr);

  initial begin
    for (int i = 0; i < 2048; i++) scr[i] = 8'(i) ^ 8'h3C;
    scr[41] = 8'hA5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx, input logic [11:0] rgb, input logic hs,
                                     input logic vs, input logic fs, input logic [15:0] bmp,
                                     input logic [10:0] va);
    check({pfx, "_rgb"}, 32'(rgb), 32'h0);
    check({pfx, "_hsync"}, 32'(hs), 32'h1);
    check({pfx, "_vsync"}, 32'(vs), 32'h1);
    check({pfx, "_fs"}, 32'(fs), 32'h0);
    check({pfx, "_bmp"}, 32'(bmp), 32'h0);
    check({pfx, "_vga_addr"}, 32'(va), 32'h0);
  endtask

  // Called on every small-DUT tick with the number of ticks since reset release.
  task automatic sb_tick(input int t);
    exp_t e, old;
    int   p, a;
    bit   vis;
    p   = t % S_FT;
    e.h = p % S_HT;
    e.v = p / S_HT;
    vis = (e.h < S_HV) && (e.v < S_VV);
    a   = vis ? (e.v / 16) * 40 + e.h / 16 : 0;
    e.bmp = {scr[a], 4'(e.v), 4'(e.h)};
    e.rgb = vis ? color_fn(e.bmp) : 12'h000;
    e.hs  = !((e.h >= S_HV + S_HFP) && (e.h < S_HV + S_HFP + S_HS));
    e.vs  = !((e.v >= S_VV + S_VFP) && (e.v < S_VV + S_VFP + S_VS));
    check("s_vga_addr", 32'(s_if.vga_addr), 32'(a));
    if (e.h == 16 && e.v == 16) check("s_addr_16_16", 32'(s_if.vga_addr), 32'd41);
    if (e.h == S_HV - 1 && e.v == S_VV - 1) check("s_addr_last", 32'(s_if.vga_addr), 32'd83);
    if (e.h == S_HV && e.v == 0) check("s_addr_hblank", 32'(s_if.vga_addr), 32'd0);
    if (e.h == 0 && e.v == S_VV) check("s_addr_vblank", 32'(s_if.vga_addr), 32'd0);
    sb_q.push_back(e);
    if (sb_q.size() >= 2) begin
      old = sb_q[$-1];
      check("s_bmp_addr", 32'(s_if.bmp_addr), 32'(old.bmp));
      if (old.h == 23 && old.v == 19) check("s_bmp_a5", 32'(s_if.bmp_addr), 32'hA537);
    end
    if (sb_q.size() == 3) begin
      old = sb_q.pop_front();
      check("s_rgb", 32'({s_if.red, s_if.green, s_if.blue}), 32'(old.rgb));
      check("s_hsync", 32'(s_if.hsync), 32'(old.hs));
      check("s_vsync", 32'(s_if.vsync), 32'(old.vs));
    end
  endtask

  task automatic run_full();
    int n = 0, first_fall = 0, rise = 0, second_fall = 0;
    logic prev_hs = 1'b1;
    bit vs_seen_low = 1'b0;
    rst_full = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("f_reset", {f_if.red, f_if.green, f_if.blue}, f_if.hsync, f_if.vsync,
                        f_if.frame_start, f_if.bmp_addr, f_if.vga_addr);
    rst_full = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (prev_hs && !f_if.hsync) begin
        if (first_fall == 0) first_fall = n;
        else if (second_fall == 0) second_fall = n;
      end
      if (!prev_hs && f_if.hsync && rise == 0) rise = n;
      prev_hs = f_if.hsync;
      if (!f_if.vsync || f_if.frame_start) vs_seen_low = 1'b1;
      case (n)
        4 * 16:  check("f_addr_16_0", 32'(f_if.vga_addr), 32'd1);
        4 * 639: check("f_addr_639_0", 32'(f_if.vga_addr), 32'd39);
        4 * 640: check("f_addr_640_0", 32'(f_if.vga_addr), 32'd0);
        4 * 816: check("f_addr_16_1", 32'(f_if.vga_addr), 32'd1);
        4 * 102: check("f_rgb_vis", 32'({f_if.red, f_if.green, f_if.blue}), 32'hFFF);
        4 * 702: check("f_rgb_blank", 32'({f_if.red, f_if.green, f_if.blue}), 32'h0);
        4 * 807: check("f_rgb_line1", 32'({f_if.red, f_if.green, f_if.blue}), 32'hFFF);
        default: ;
      endcase
    end
    check("f_hs_first_fall", 32'(first_fall), 32'd2632);
    check("f_hs_low_clks", 32'(rise - first_fall), 32'd384);
    check("f_hs_period", 32'(second_fall - first_fall), 32'd3200);
    check("f_vs_idle", 32'(vs_seen_low), 32'd0);
  endtask

  task automatic small_step(inout int n, inout int fs_cnt, inout int vs_cnt);
    @(posedge clk);
    @(negedge clk);
    n++;
    check("s_frame_start", 32'(s_if.frame_start),
          32'((n % S_DIV == 0) && ((n / S_DIV) % S_FT == 0)));
    if (s_if.frame_start) fs_cnt++;
    if (n % S_DIV == 0) begin
      if (!s_if.vsync) vs_cnt++;
      sb_tick(n / S_DIV);
    end
  endtask

  task automatic run_small();
    int n = 0, fs_cnt = 0, vs_cnt = 0;
    rst_small = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("s_reset", {s_if.red, s_if.green, s_if.blue}, s_if.hsync, s_if.vsync,
                        s_if.frame_start, s_if.bmp_addr, s_if.vga_addr);
    sb_q.delete();
    sb_tick(0);
    rst_small = 1'b0;
    for (int k = 0; k < S_DIV * T_RST + 1; k++) small_step(n, fs_cnt, vs_cnt);
    check("s_fs_count_1", 32'(fs_cnt), 32'd1);
    check("s_vs_low_ticks_1", 32'(vs_cnt), 32'(S_VS * S_HT));
    // Mid-line, mid-tick single-clock reset.
    rst_small = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_small = 1'b0;
    check_reset_outputs("s_midreset", {s_if.red, s_if.green, s_if.blue}, s_if.hsync,
                        s_if.vsync, s_if.frame_start, s_if.bmp_addr, s_if.vga_addr);
    n = 0;
    fs_cnt = 0;
    vs_cnt = 0;
    sb_q.delete();
    sb_tick(0);
    for (int k = 0; k < S_DIV * (S_FT + 200); k++) small_step(n, fs_cnt, vs_cnt);
    check("s_fs_count_2", 32'(fs_cnt), 32'd1);
    check("s_vs_low_ticks_2", 32'(vs_cnt), 32'(S_VS * S_HT));
  endtask

  initial begin
    fork
      run_full();
      run_small();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
